// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
// Circular free list of physical-register tags feeding rename. Commit returns
// tags at the tail and rename takes them from the head. One head-pointer
// checkpoint allows single-cycle branch-mispredict recovery.
// Optional feature macro: FREE_LIST_BYPASS_EN. When defined, a tag released
// into an empty list is presented on alloc_tag in the same cycle. If an alloc
// takes it, the tag is never written into storage.
// Reset port rst_n is asynchronous and active-high.
module phys_reg_free_list #(
   parameter int PHYS_REGS = 64,
   parameter int ARCH_REGS = 32,
   localparam int DEPTH    = PHYS_REGS - ARCH_REGS,
   localparam int TAG_W    = $clog2(PHYS_REGS),
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_req,
   output logic             alloc_valid,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             release_valid,
   input  logic [TAG_W-1:0] release_tag,
   input  logic             checkpoint_req,
   input  logic             recover,
   output logic [CNT_W-1:0] free_count,
   output logic             overflow_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [TAG_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [PTR_W-1:0] ckpt_r;
   logic             overflow_r;

   logic [PTR_W-1:0] count_s;
   logic [PTR_W-1:0] head_nxt_s;
   logic [PTR_W-1:0] tail_nxt_s;
   logic             empty_s;
   logic             full_s;
   logic             alloc_fire_s;
   logic             bypass_fire_s;
   logic             rel_accept_s;
   logic             rel_drop_s;
   logic             head_inc_s;
   logic             tail_inc_s;

   // Occupancy flags; the wrap bit disambiguates full from empty.
   always_comb begin
      count_s = tail_r - head_r;
      empty_s = (count_s == {PTR_W{1'b0}});
      full_s  = (count_s == PTR_W'(DEPTH));
   end

   // Show-ahead head tag, optionally bypassing a release into an empty list.
   always_comb begin
      alloc_valid = ~empty_s;
      alloc_tag   = mem_r[head_r[IDX_W-1:0]];
`ifdef FREE_LIST_BYPASS_EN
      if (empty_s && release_valid) begin
         alloc_valid = 1'b1;
         alloc_tag   = release_tag;
      end else begin
         alloc_valid = ~empty_s;
         alloc_tag   = mem_r[head_r[IDX_W-1:0]];
      end
`endif
   end

   // Alloc/release decisions; recover blocks the alloc but not the release.
   always_comb begin
      alloc_fire_s = alloc_req && alloc_valid && !recover;
`ifdef FREE_LIST_BYPASS_EN
      bypass_fire_s = empty_s && release_valid && alloc_fire_s;
`else
      bypass_fire_s = 1'b0;
`endif
      rel_accept_s = release_valid && (!full_s || alloc_fire_s);
      rel_drop_s   = release_valid && full_s && !alloc_fire_s;
      head_inc_s   = alloc_fire_s && !bypass_fire_s;
      tail_inc_s   = rel_accept_s && !bypass_fire_s;
   end

   // Next head (recover wins over alloc) and next tail.
   always_comb begin
      if (recover) begin
         head_nxt_s = ckpt_r;
      end else if (head_inc_s) begin
         head_nxt_s = head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         head_nxt_s = head_r;
      end
      if (tail_inc_s) begin
         tail_nxt_s = tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         tail_nxt_s = tail_r;
      end
   end

   // Pointer, checkpoint and sticky overflow state.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         head_r     <= {PTR_W{1'b0}};
         tail_r     <= PTR_W'(DEPTH);
         ckpt_r     <= {PTR_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         head_r <= head_nxt_s;
         tail_r <= tail_nxt_s;
         if (checkpoint_req && !recover) begin
            ckpt_r <= head_nxt_s;
         end
         if (rel_drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Tag storage; reset preloads the unmapped tags ARCH_REGS..PHYS_REGS-1.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= TAG_W'(ARCH_REGS + i);
         end
      end else begin
         if (tail_inc_s) begin
            mem_r[tail_r[IDX_W-1:0]] <= release_tag;
         end
      end
   end

   assign free_count   = CNT_W'(count_s);
   assign overflow_err = overflow_r;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed testbench for phys_reg_free_list with a scoreboard of expected
// tags and immediate-assertion checks. Honors FREE_LIST_BYPASS_EN.
module tb_phys_reg_free_list;

   localparam int TAG_W = 6;
   localparam int CNT_W = 6;

   logic             clk;
   logic             rst_n;
   logic             alloc_req;
   logic             alloc_valid;
   logic [TAG_W-1:0] alloc_tag;
   logic             release_valid;
   logic [TAG_W-1:0] release_tag;
   logic             checkpoint_req;
   logic             recover;
   logic [CNT_W-1:0] free_count;
   logic             overflow_err;

   int errors = 0;
   int checks = 0;
   int unsigned exp_q[$];

   phys_reg_free_list dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alloc_req      (alloc_req),
      .alloc_valid    (alloc_valid),
      .alloc_tag      (alloc_tag),
      .release_valid  (release_valid),
      .release_tag    (release_tag),
      .checkpoint_req (checkpoint_req),
      .recover        (recover),
      .free_count     (free_count),
      .overflow_err   (overflow_err)
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", name, obs, exp);
      end
   endtask

   task automatic push(input int unsigned v);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input string name, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: got %0d expected <scoreboard entry>", name, obs);
      end else begin
         e = exp_q.pop_front();
         chk(name, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      alloc_req = 1'b0; release_valid = 1'b0; release_tag = '0;
      checkpoint_req = 1'b0; recover = 1'b0;
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
   endtask

   // Allocate n tags, comparing each against the scoreboard.
   task automatic alloc_n(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         alloc_req = 1'b1;
         #1;
         pop_check(name, {26'd0, alloc_tag});
         chk({name, "_valid"}, {31'd0, alloc_valid}, 32'd1);
         tick();
      end
      alloc_req = 1'b0;
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      alloc_req = 1'b0; release_valid = 1'b0; release_tag = '0;
      checkpoint_req = 1'b0; recover = 1'b0;

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid", {31'd0, alloc_valid}, 32'd1);
      chk("rst_tag", {26'd0, alloc_tag}, 32'd32);
      chk("rst_count", {26'd0, free_count}, 32'd32);
      chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
      rst_n = 1'b0;
      tick();

      // Drain: tags 32..63 in order, then empty.
      for (int i = 0; i < 32; i++) push(32 + i);
      alloc_n(32, "drain_tag");
      chk("drain_valid", {31'd0, alloc_valid}, 32'd0);
      chk("drain_count", {26'd0, free_count}, 32'd0);

      // Release 5, 6, 7 into the empty list.
      release_valid = 1'b1; release_tag = 6'd5;
      #1;
`ifdef FREE_LIST_BYPASS_EN
      chk("empty_rel_valid", {31'd0, alloc_valid}, 32'd1);
      chk("empty_rel_tag", {26'd0, alloc_tag}, 32'd5);
`else
      chk("empty_rel_valid", {31'd0, alloc_valid}, 32'd0);
`endif
      tick();
      release_tag = 6'd6;
      #1;
      chk("rel5_tag", {26'd0, alloc_tag}, 32'd5);
      chk("rel5_count", {26'd0, free_count}, 32'd1);
      tick();
      release_tag = 6'd7;
      tick();
      release_valid = 1'b0;
      #1;
      chk("rel567_count", {26'd0, free_count}, 32'd3);
      push(5); push(6); push(7);
      alloc_n(3, "wrap_tag");
      chk("wrap_count", {26'd0, free_count}, 32'd0);
      chk("wrap_valid", {31'd0, alloc_valid}, 32'd0);

      // Checkpoint and recover.
      do_reset();
      push(32); push(33);
      alloc_n(2, "ck_pre_tag");
      checkpoint_req = 1'b1;
      tick();
      checkpoint_req = 1'b0;
      push(34); push(35); push(36);
      alloc_n(3, "ck_post_tag");
      release_valid = 1'b1; release_tag = 6'd9;
      #1;
      chk("ck_count_27", {26'd0, free_count}, 32'd27);
      tick();
      release_valid = 1'b0;
      recover = 1'b1;
      tick();
      recover = 1'b0;
      #1;
      chk("rec_tag", {26'd0, alloc_tag}, 32'd34);
      chk("rec_count", {26'd0, free_count}, 32'd31);
      for (int i = 34; i < 64; i++) push(i);
      push(9);
      alloc_n(31, "rec_drain_tag");
      chk("rec_drain_count", {26'd0, free_count}, 32'd0);

      // Overflow: drop when full, accept with a simultaneous alloc.
      do_reset();
      release_valid = 1'b1; release_tag = 6'd7;
      tick();
      release_valid = 1'b0;
      #1;
      chk("ovf_set", {31'd0, overflow_err}, 32'd1);
      chk("ovf_count", {26'd0, free_count}, 32'd32);
      chk("ovf_tag", {26'd0, alloc_tag}, 32'd32);
      release_valid = 1'b1; alloc_req = 1'b1;
      #1;
      chk("ovf_alloc_tag", {26'd0, alloc_tag}, 32'd32);
      tick();
      release_valid = 1'b0; alloc_req = 1'b0;
      #1;
      chk("ovf_acc_count", {26'd0, free_count}, 32'd32);
      chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);
      for (int i = 33; i < 64; i++) push(i);
      push(7);
      alloc_n(32, "ovf_drain_tag");
      chk("ovf_sticky2", {31'd0, overflow_err}, 32'd1);

      // All head-side events plus a release in one cycle.
      do_reset();
      push(32);
      alloc_n(1, "sim_a_tag");
      checkpoint_req = 1'b1;
      tick();
      checkpoint_req = 1'b0;
      push(33); push(34);
      alloc_n(2, "sim_b_tag");
      recover = 1'b1; alloc_req = 1'b1; checkpoint_req = 1'b1;
      release_valid = 1'b1; release_tag = 6'd20;
      tick();
      recover = 1'b0; alloc_req = 1'b0; checkpoint_req = 1'b0; release_valid = 1'b0;
      #1;
      chk("sim_tag", {26'd0, alloc_tag}, 32'd33);
      chk("sim_count", {26'd0, free_count}, 32'd32);
      push(33);
      alloc_n(1, "sim_c_tag");
      recover = 1'b1;
      tick();
      recover = 1'b0;
      #1;
      chk("sim_ckpt_tag", {26'd0, alloc_tag}, 32'd33);
      chk("sim_ckpt_count", {26'd0, free_count}, 32'd32);
      for (int i = 33; i < 64; i++) push(i);
      push(20);
      alloc_n(32, "sim_drain_tag");

      // Empty list with release and alloc in the same cycle.
      release_valid = 1'b1; release_tag = 6'd12; alloc_req = 1'b1;
      #1;
`ifdef FREE_LIST_BYPASS_EN
      chk("byp_valid", {31'd0, alloc_valid}, 32'd1);
      chk("byp_tag", {26'd0, alloc_tag}, 32'd12);
      tick();
      release_valid = 1'b0; alloc_req = 1'b0;
      #1;
      chk("byp_count", {26'd0, free_count}, 32'd0);
      chk("byp_after_valid", {31'd0, alloc_valid}, 32'd0);
`else
      chk("byp_valid", {31'd0, alloc_valid}, 32'd0);
      tick();
      release_valid = 1'b0; alloc_req = 1'b0;
      #1;
      chk("byp_count", {26'd0, free_count}, 32'd1);
      chk("byp_tag", {26'd0, alloc_tag}, 32'd12);
`endif

      // Asynchronous reset between clock edges.
      do_reset();
      release_valid = 1'b1; release_tag = 6'd7;
      tick();
      release_valid = 1'b0;
      alloc_req = 1'b1;
      repeat (10) tick();
      alloc_req = 1'b0;
      #1;
      chk("mid_pre_tag", {26'd0, alloc_tag}, 32'd42);
      chk("mid_pre_ovf", {31'd0, overflow_err}, 32'd1);
      #1;
      rst_n = 1'b1;
      #1;
      chk("mid_rst_tag", {26'd0, alloc_tag}, 32'd32);
      chk("mid_rst_count", {26'd0, free_count}, 32'd32);
      chk("mid_rst_ovf", {31'd0, overflow_err}, 32'd0);
      chk("mid_rst_valid", {31'd0, alloc_valid}, 32'd1);
      tick();
      rst_n = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
